// File: rtl/uart_rx_ctrl_if.sv
// Receive-side bundle for uart_rx_ctrl.
// The master (the environment) drives the oversample strobe, the serial line and the enable.
// The slave (the receiver) returns the parallel word, the result pulses and the busy flag.
//   RX_tick      : one-clock oversample strobe from the baud generator
//   SER_DATA     : asynchronous serial line, idle high
//   RX_EN        : receiver enable
//   P_DATA       : last good word, LSB = first received bit
//   DATA_VALID   : one-clock pulse when P_DATA is updated
//   PARITY_ERROR : one-clock pulse on a parity fault
//   STOP_ERROR   : one-clock pulse on a low stop bit
//   BUSY         : receiver is not idle
interface uart_rx_ctrl_if #(parameter int DATA_WIDTH = 8);
  logic                  RX_tick;
  logic                  SER_DATA;
  logic                  RX_EN;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PARITY_ERROR;
  logic                  STOP_ERROR;
  logic                  BUSY;

  modport master (
    output RX_tick, SER_DATA, RX_EN,
    input  P_DATA, DATA_VALID, PARITY_ERROR, STOP_ERROR, BUSY
  );

  modport slave (
    input  RX_tick, SER_DATA, RX_EN,
    output P_DATA, DATA_VALID, PARITY_ERROR, STOP_ERROR, BUSY
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Parametrised UART receive controller.
// It synchronises the serial line and validates the start bit at mid-bit.
// It shifts in DATA_WIDTH bits LSB first, then checks an optional parity bit and 1 or 2 stop bits.
// Each frame produces one registered result pulse: DATA_VALID for a clean frame,
// or PARITY_ERROR and/or STOP_ERROR for a bad one.
//   CLK : system clock
//   RST : asynchronous active-low reset
//   bus : uart_rx_ctrl_if slave modport (RX_tick, SER_DATA, RX_EN in; P_DATA,
//         DATA_VALID, PARITY_ERROR, STOP_ERROR, BUSY out)
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic         CLK,
  input  logic         RST,
  uart_rx_ctrl_if.slave bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MID   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END   = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic          ODD_BIT   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
  localparam logic          HAS_PAR   = (PARITY_EN != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_r, state_s;
  logic [CW-1:0]         cnt_r, cnt_s;
  logic [BW-1:0]         bit_r, bit_s;
  logic                  stop_idx_r, stop_idx_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_s;
  logic                  perr_r, perr_s;
  logic                  serr_r, serr_s;
  logic                  done_r, done_s;
  logic [1:0]            sync_r;
  logic                  rxs_s;
  logic [DATA_WIDTH-1:0] pdata_r;
  logic                  valid_r, perr_out_r, serr_out_r, busy_r;

  // Parity fault: data XOR parity bit must equal the configured sense.
  function automatic logic parity_fault(input logic [DATA_WIDTH-1:0] d, input logic p);
    return ((^d) ^ p) != ODD_BIT;
  endfunction

  assign rxs_s = sync_r[1];

  // Two-flop synchroniser; runs every clock regardless of RX_tick.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync_r <= 2'b11;
    else      sync_r <= {sync_r[0], bus.SER_DATA};
  end

  // Next-state logic; all sampling decisions happen only on RX_tick cycles.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    bit_s      = bit_r;
    stop_idx_s = stop_idx_r;
    shift_s    = shift_r;
    perr_s     = perr_r;
    serr_s     = serr_r;
    done_s     = 1'b0;
    if (!bus.RX_EN) begin
      // Enable low discards any partial frame without a result pulse.
      state_s    = IDLE;
      cnt_s      = '0;
      bit_s      = '0;
      stop_idx_s = 1'b0;
    end else if (bus.RX_tick) begin
      // Counter wraps OVERSAMPLE-1 -> 0 on its own (power-of-2 width).
      cnt_s = cnt_r + CW'(1);
      case (state_r)
        IDLE: begin
          cnt_s      = '0;
          bit_s      = '0;
          stop_idx_s = 1'b0;
          if (!rxs_s) begin
            state_s = START;
            perr_s  = 1'b0;
            serr_s  = 1'b0;
          end else begin
            state_s = IDLE;
          end
        end
        START: begin
          if (cnt_r == CNT_MID) begin
            cnt_s   = '0;
            bit_s   = '0;
            state_s = rxs_s ? IDLE : DATA;
          end else begin
            state_s = START;
          end
        end
        DATA: begin
          if (cnt_r == CNT_END) begin
            shift_s = {rxs_s, shift_r[DATA_WIDTH-1:1]};
            if (bit_r == BIT_LAST) begin
              bit_s      = '0;
              cnt_s      = '0;
              stop_idx_s = 1'b0;
              state_s    = HAS_PAR ? PARITY : STOP;
            end else begin
              bit_s = bit_r + BW'(1);
            end
          end else begin
            state_s = DATA;
          end
        end
        PARITY: begin
          if (cnt_r == CNT_END) begin
            perr_s     = parity_fault(shift_r, rxs_s);
            cnt_s      = '0;
            stop_idx_s = 1'b0;
            state_s    = STOP;
          end else begin
            state_s = PARITY;
          end
        end
        STOP: begin
          if (cnt_r == CNT_END) begin
            serr_s = serr_r | ~rxs_s;
            if (stop_idx_r == STOP_LAST) begin
              // Leave at mid-stop-bit so a following start edge is not missed.
              state_s = IDLE;
              cnt_s   = '0;
              done_s  = 1'b1;
            end else begin
              stop_idx_s = 1'b1;
            end
          end else begin
            state_s = STOP;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Frame state registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      bit_r      <= '0;
      stop_idx_r <= 1'b0;
      shift_r    <= '0;
      perr_r     <= 1'b0;
      serr_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      bit_r      <= bit_s;
      stop_idx_r <= stop_idx_s;
      shift_r    <= shift_s;
      perr_r     <= perr_s;
      serr_r     <= serr_s;
      done_r     <= done_s;
    end
  end

  // Result stage: one clock after the final stop sample, publish data or error pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pdata_r    <= '0;
      valid_r    <= 1'b0;
      perr_out_r <= 1'b0;
      serr_out_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      valid_r    <= 1'b0;
      perr_out_r <= 1'b0;
      serr_out_r <= 1'b0;
      busy_r     <= (state_s != IDLE);
      if (done_r) begin
        if (!perr_r && !serr_r) begin
          pdata_r <= shift_r;
          valid_r <= 1'b1;
        end else begin
          perr_out_r <= perr_r;
          serr_out_r <= serr_r;
        end
      end
    end
  end

  assign bus.P_DATA       = pdata_r;
  assign bus.DATA_VALID   = valid_r;
  assign bus.PARITY_ERROR = perr_out_r;
  assign bus.STOP_ERROR   = serr_out_r;
  assign bus.BUSY         = busy_r;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Parametrised UART receive controller that replaces the fixed 8-bit RX FSM. It integrates the input synchroniser, oversample tick counter, start-bit validation, deserialiser, configurable parity check and 1/2 stop-bit check. It sits between the baud-rate generator, which supplies the RX_tick strobe, and the RX data consumer. It emits one word per error-free frame, or an error pulse per bad frame.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
OVERSAMPLE, 16, RX_tick pulses per bit period; a power of 2, minimum 8.
PARITY_EN, 1, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits checked; 1 or 2.

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous active-low reset
RX_tick  input  1  one-CLK-wide oversample strobe
SER_DATA  input  1  asynchronous serial line; idle high
RX_EN  input  1  receiver enable; low forces IDLE
P_DATA  output  DATA_WIDTH  last good word, LSB = first received bit
DATA_VALID  output  1  one-CLK pulse when P_DATA is updated
PARITY_ERROR  output  1  one-CLK pulse, bad parity
STOP_ERROR  output  1  one-CLK pulse, a stop bit sampled low
BUSY  output  1  high in any state other than IDLE

Behaviour:
- Reset (RST low, asynchronous):
  - Outputs: P_DATA=0, DATA_VALID=0, PARITY_ERROR=0, STOP_ERROR=0, BUSY=0.
  - Internal: state=IDLE, tick counter=0, bit index=0, synchroniser flops=1.
- Synchroniser: SER_DATA passes through 2 flops on CLK; all samples use the synchronised value (rxs).
- Tick counter: width log2(OVERSAMPLE). Advances only on CLK edges where RX_tick=1. Cleared on every state entry. Wraps from OVERSAMPLE-1 to 0.
- State machine (transitions occur only on RX_tick cycles, except the RX_EN abort):
  - IDLE: if RX_EN=1 and rxs=0, go to START with counter=0.
  - START: at count OVERSAMPLE/2-1 (mid start bit), re-sample rxs. If rxs=1 (glitch), return to IDLE with no outputs. If rxs=0, go to DATA with counter=0 and bit index=0.
  - DATA: at count OVERSAMPLE-1, shift rxs into the shift register (LSB first) and increment the bit index. After bit DATA_WIDTH-1, go to PARITY if PARITY_EN=1, else go to STOP.
  - PARITY: at count OVERSAMPLE-1, sample the parity bit. Error if (XOR of data bits XOR parity bit) != PARITY_ODD. Latch the error internally; no early abort. Then go to STOP.
  - STOP: at count OVERSAMPLE-1, sample each stop bit; any stop bit sampled 0 latches a stop error. After the last stop sample, go to IDLE immediately, at mid-stop-bit, so a start edge arriving half a bit later is caught.
- Result, registered on the CLK edge following the final stop sample:
  - No errors: P_DATA <= shift register, DATA_VALID=1 for one CLK.
  - Any error: P_DATA is held. PARITY_ERROR and/or STOP_ERROR pulse for one CLK, both together when both faults occurred. DATA_VALID stays 0.
- RX_EN=0 in any state: return to IDLE on the next CLK edge, discard the partial frame, no pulses. P_DATA is held.
- Sampling points: the sampling instants are bit-centre relative to the detected start edge.
- RX_tick low: the FSM and counter freeze, but the synchroniser keeps running.
- Reset asserted mid-frame: immediate return to reset values; no pulse on release.
- Error flags are not sticky; the consumer must capture the pulses.

Test Plan:
- 8N1 (PARITY_EN=0, OVERSAMPLE=16), frame 0xA5 → exactly one DATA_VALID pulse with P_DATA=0xA5, no error pulses, BUSY back to 0 within 8 ticks of the stop-bit centre.
- 8E1, data 0x03 with parity bit 1 (wrong) → PARITY_ERROR one-CLK pulse, DATA_VALID=0, P_DATA keeps its previous value.
- SER_DATA low for 3 ticks, then high → START aborts at tick 7, BUSY returns to 0, no output pulses.
- 8N2, second stop bit driven 0 → STOP_ERROR pulse, DATA_VALID=0. Repeat with STOP_BITS=1: clean receive.
- Back-to-back frames 0x55 then 0xFF with no idle gap → two DATA_VALID pulses, P_DATA=0x55 then 0xFF.
- RST low during DATA bit 4, released, then a clean 0x3C frame → all outputs 0 during reset, only one DATA_VALID (0x3C). Repeat with RX_EN dropped mid-frame: no pulse for the aborted frame.
